// File: rtl/adc_clip_window_monitor.sv
// adc_clip_window_monitor: counts clip_in cycles over back-to-back programmable windows (ADC_CLIP_RUN_LENGTH_EN adds max_run).
// Latency: count/alarm/max_run register on the last window sample; count_valid strobes on the following ce-cycle.
// Backpressure: none; ce=0 freezes all state and suppresses count_valid.
module adc_clip_window_monitor #(
  parameter int WIN_WIDTH   = 32,
  parameter int COUNT_WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   ce,
  input  logic                   clip_in,
  input  logic                   arm,
  input  logic [WIN_WIDTH-1:0]   win_len,
  input  logic [COUNT_WIDTH-1:0] threshold,
  input  logic                   clear_sticky,
  output logic [COUNT_WIDTH-1:0] clip_count,
  output logic                   count_valid,
  output logic                   alarm,
  output logic                   sticky_clip,
  output logic                   busy
`ifdef ADC_CLIP_RUN_LENGTH_EN
  ,
  output logic [COUNT_WIDTH-1:0] max_run
`endif
);

  typedef enum logic [1:0] {IDLE, LOAD, COUNT, PUBLISH} state_t;

  state_t                 state_q;
  state_t                 state_d;
  logic [WIN_WIDTH-1:0]   len_q;
  logic [WIN_WIDTH-1:0]   cyc_q;
  logic [WIN_WIDTH-1:0]   len_cur;
  logic [WIN_WIDTH-1:0]   cyc_d;
  logic [COUNT_WIDTH-1:0] acc_q;
  logic [COUNT_WIDTH-1:0] acc_d;
  logic                   sample;
  logic                   first;
  logic                   last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else if (ce) begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    sample      = 1'b0;
    first       = 1'b0;
    count_valid = 1'b0;
    case (state_q)
      IDLE: begin
        if (arm) state_d = LOAD;
      end
      LOAD: begin
        sample = 1'b1;
        first  = 1'b1;
      end
      COUNT: begin
        sample = 1'b1;
      end
      PUBLISH: begin
        count_valid = ce;
        // An armed publish cycle doubles as the first sample of the next window.
        if (arm) begin
          sample = 1'b1;
          first  = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    busy    = sample;
    len_cur = first ? ((win_len == '0) ? WIN_WIDTH'(1) : win_len) : len_q;
    cyc_d   = first ? WIN_WIDTH'(1) : cyc_q + WIN_WIDTH'(1);
    last    = (cyc_d == len_cur);
    acc_d   = first ? COUNT_WIDTH'(clip_in)
                    : ((&acc_q) ? acc_q : acc_q + COUNT_WIDTH'(clip_in));

    if (sample) state_d = last ? PUBLISH : COUNT;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      len_q       <= '0;
      cyc_q       <= '0;
      acc_q       <= '0;
      clip_count  <= '0;
      alarm       <= 1'b0;
      sticky_clip <= 1'b0;
    end else if (ce) begin
      if (sample) begin
        len_q <= len_cur;
        cyc_q <= cyc_d;
        acc_q <= acc_d;
        if (last) begin
          clip_count <= acc_d;
          alarm      <= (acc_d >= threshold);
        end
      end
      // A new clip wins over a coincident clear.
      if (sample && clip_in) begin
        sticky_clip <= 1'b1;
      end else if (clear_sticky) begin
        sticky_clip <= 1'b0;
      end
    end
  end

`ifdef ADC_CLIP_RUN_LENGTH_EN
  logic [COUNT_WIDTH-1:0] run_q;
  logic [COUNT_WIDTH-1:0] run_d;
  logic [COUNT_WIDTH-1:0] mrun_q;
  logic [COUNT_WIDTH-1:0] mrun_d;

  always_comb begin
    run_d = '0;
    if (clip_in) begin
      run_d = first ? COUNT_WIDTH'(1)
                    : ((&run_q) ? run_q : run_q + COUNT_WIDTH'(1));
    end
    mrun_d = (first || (run_d > mrun_q)) ? run_d : mrun_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_q   <= '0;
      mrun_q  <= '0;
      max_run <= '0;
    end else if (ce && sample) begin
      run_q  <= run_d;
      mrun_q <= mrun_d;
      if (last) max_run <= mrun_d;
    end
  end
`endif

endmodule

// File: tb/tb_adc_clip_window_monitor.sv
// Randomized and directed bench for adc_clip_window_monitor against a queue-based window model.
module tb_adc_clip_window_monitor;
  localparam int WW = 32;
  localparam int CW = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          ce;
  logic          clip_in;
  logic          arm;
  logic          clear_sticky;
  logic [WW-1:0] win_len;
  logic [CW-1:0] threshold;
  logic [CW-1:0] clip_count;
  logic          count_valid;
  logic          alarm;
  logic          sticky_clip;
  logic          busy;
`ifdef ADC_CLIP_RUN_LENGTH_EN
  logic [CW-1:0] max_run;
`endif

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  adc_clip_window_monitor #(.WIN_WIDTH(WW), .COUNT_WIDTH(CW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .ce           (ce),
    .clip_in      (clip_in),
    .arm          (arm),
    .win_len      (win_len),
    .threshold    (threshold),
    .clear_sticky (clear_sticky),
    .clip_count   (clip_count),
    .count_valid  (count_valid),
    .alarm        (alarm),
    .sticky_clip  (sticky_clip),
    .busy         (busy)
`ifdef ADC_CLIP_RUN_LENGTH_EN
    ,
    .max_run      (max_run)
`endif
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  // Reference model: a window is the list of ce-sampled clip bits; results come from that list.
  bit            m_load   = 1'b0;  // next ce-cycle opens a window from idle
  bit            m_inwin  = 1'b0;  // a window is partially filled
  bit            m_pub    = 1'b0;  // this ce-cycle presents a freshly closed window
  bit            m_alarm  = 1'b0;
  bit            m_sticky = 1'b0;
  int unsigned   m_len    = 1;
  bit            m_samp[$];
  logic [CW-1:0] m_count  = '0;
  logic [CW-1:0] m_run    = '0;
  bit            mv_new, mv_samp, mv_idle, mv_npub;

  function automatic int q_sum();
    int s = 0;
    foreach (m_samp[i]) s += int'(m_samp[i]);
    return s;
  endfunction

  function automatic int q_longest();
    int best = 0;
    int cur  = 0;
    foreach (m_samp[i]) begin
      cur = m_samp[i] ? cur + 1 : 0;
      if (cur > best) best = cur;
    end
    return best;
  endfunction

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      m_load = 0; m_inwin = 0; m_pub = 0; m_alarm = 0; m_sticky = 0;
      m_count = '0; m_run = '0;
      m_samp.delete();
    end else if (ce) begin
      mv_new  = m_load || (m_pub && arm);
      mv_samp = mv_new || m_inwin;
      mv_idle = !m_load && !m_inwin && !m_pub;
      if (mv_samp && clip_in) m_sticky = 1;
      else if (clear_sticky)  m_sticky = 0;
      mv_npub = 0;
      if (mv_samp) begin
        if (mv_new) begin
          m_samp.delete();
          m_len = (win_len == 0) ? 1 : win_len;
        end
        m_samp.push_back(clip_in);
        if (m_samp.size() == int'(m_len)) begin
          m_count = CW'(q_sum());
          m_alarm = (CW'(q_sum()) >= threshold);
          m_run   = CW'(q_longest());
          mv_npub = 1;
          m_inwin = 0;
        end else begin
          m_inwin = 1;
        end
      end
      m_pub  = mv_npub;
      m_load = mv_idle && arm;
    end
  end

  // Compare process: every negedge, all outputs against the model.
  initial forever begin
    @(negedge clk);
    check("count_valid", 64'(count_valid), 64'(ce && m_pub));
    check("busy", 64'(busy), 64'(m_load || m_inwin || (m_pub && arm)));
    check("clip_count", 64'(clip_count), 64'(m_count));
    check("alarm", 64'(alarm), 64'(m_alarm));
    check("sticky_clip", 64'(sticky_clip), 64'(m_sticky));
`ifdef ADC_CLIP_RUN_LENGTH_EN
    check("max_run", 64'(max_run), 64'(m_run));
`endif
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: bench did not reach its summary");
    $fatal(1, "timeout");
  end

  // One window from idle: clip bits pat[k-1] at ce-cycle k; arm drops on the publish cycle.
  task automatic run_win(input string tag, input int len_in, input logic [31:0] pat,
                         input bit half, input int exp_cnt, input int exp_run);
    int            L;
    int            nv;
    int            kv;
    logic [CW-1:0] cc;
    logic [CW-1:0] mr;
    L  = (len_in == 0) ? 1 : len_in;
    nv = 0; kv = -1; cc = '0; mr = '0;
    win_len = WW'(len_in);
    for (int k = 0; k <= L + 2; k++) begin
      if (half) begin
        ce = 1'b0; arm = (k <= L); clip_in = 1'($urandom_range(0, 1));
        @(negedge clk);
        check({tag, "_cv_when_ce0"}, 64'(count_valid), 64'(0));
        @(posedge clk); #1;
      end
      ce = 1'b1; arm = (k <= L);
      clip_in = (k >= 1 && k <= L) ? pat[k-1] : 1'b0;
      @(negedge clk);
      if (count_valid) begin
        nv++; kv = k; cc = clip_count;
`ifdef ADC_CLIP_RUN_LENGTH_EN
        mr = max_run;
`endif
      end
      @(posedge clk); #1;
    end
    check({tag, "_nvalid"}, 64'(nv), 64'(1));
    check({tag, "_valid_cycle"}, 64'(kv), 64'(L + 1));
    check({tag, "_count"}, 64'(cc), 64'(exp_cnt));
`ifdef ADC_CLIP_RUN_LENGTH_EN
    check({tag, "_max_run"}, 64'(mr), 64'(exp_run));
`else
    if (exp_run < 0) check({tag, "_run_arg"}, 64'(exp_run), 64'(0));
`endif
  endtask

  initial begin
    rst_n = 1'b0; ce = 1'b1; clip_in = 1'b0; arm = 1'b0; clear_sticky = 1'b0;
    win_len = '0; threshold = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("idle_busy", 64'(busy), 64'(0));
      check("idle_cv", 64'(count_valid), 64'(0));
      @(posedge clk); #1;
    end

    threshold = CW'(3);
    run_win("w16", 16, 32'h0000_8452, 1'b0, 5, 1);

    // Back-to-back windows of 8 with a constant clip
    threshold = '0; win_len = WW'(8); ce = 1'b1; clip_in = 1'b1;
    for (int k = 0; k <= 34; k++) begin
      arm = (k < 33);
      @(negedge clk);
      check("b2b_cv", 64'(count_valid), 64'((k >= 9) && ((k - 9) % 8 == 0)));
      if (count_valid) check("b2b_count", 64'(clip_count), 64'(8));
      @(posedge clk); #1;
    end

    // Alarm threshold 4: windows with 3 then 4 clips
    threshold = CW'(4); win_len = WW'(8);
    for (int k = 0; k <= 18; k++) begin
      arm = (k < 17);
      clip_in = ((k >= 1) && (k <= 3)) || ((k >= 9) && (k <= 12));
      @(negedge clk);
      if (k == 9) begin
        check("thr_alarm_first", 64'(alarm), 64'(0));
        check("thr_count_first", 64'(clip_count), 64'(3));
      end
      if (k == 17) begin
        check("thr_alarm_second", 64'(alarm), 64'(1));
        check("thr_count_second", 64'(clip_count), 64'(4));
      end
      @(posedge clk); #1;
    end

    // Asynchronous reset in the middle of a window
    arm = 1'b1; win_len = WW'(8); clip_in = 1'b1;
    repeat (4) begin @(posedge clk); #1; end
    #2 rst_n = 1'b0;
    #1;
    check("arst_busy", 64'(busy), 64'(0));
    check("arst_cv", 64'(count_valid), 64'(0));
    check("arst_count", 64'(clip_count), 64'(0));
    check("arst_alarm", 64'(alarm), 64'(0));
    check("arst_sticky", 64'(sticky_clip), 64'(0));
    @(posedge clk); #1;
    rst_n = 1'b1; arm = 1'b0; clip_in = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("post_rst_busy", 64'(busy), 64'(0));
      check("post_rst_cv", 64'(count_valid), 64'(0));
      @(posedge clk); #1;
    end

    // Sticky: set, clear coincident with a clip (stays), clear alone (drops)
    win_len = WW'(8);
    for (int k = 0; k <= 10; k++) begin
      arm = (k < 9);
      clip_in = (k == 1) || (k == 2);
      clear_sticky = (k == 2) || (k == 3);
      @(negedge clk);
      if (k == 3) check("sticky_set_wins", 64'(sticky_clip), 64'(1));
      if (k == 4) check("sticky_cleared", 64'(sticky_clip), 64'(0));
      @(posedge clk); #1;
    end
    clear_sticky = 1'b0;

    run_win("len0", 0, 32'h0000_0001, 1'b0, 1, 1);
    run_win("run7", 7, 32'h0000_003B, 1'b0, 5, 3);
    run_win("w16_half", 16, 32'h0000_8452, 1'b1, 5, 1);
    run_win("run7_half", 7, 32'h0000_003B, 1'b1, 5, 3);

    // Randomized phase
    arm = 1'b1; win_len = WW'(3);
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 15) == 0) arm = ~arm;
      ce           = ($urandom_range(0, 3) != 0);
      clip_in      = 1'($urandom_range(0, 1));
      clear_sticky = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 31) == 0) win_len = WW'($urandom_range(0, 6));
      if ($urandom_range(0, 63) == 0) threshold = CW'($urandom_range(0, 7));
      if (i % 1300 == 700) begin
        #2 rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
      end else begin
        @(posedge clk); #1;
      end
    end

    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
